// File: rtl/approx_mac_stream.sv
// Streaming multiply-accumulate with a per-beat selectable approximate multiplier.
// Pipeline: operand register -> product register -> accumulator -> result register, with a global stall.
module approx_mac_stream #(
  parameter  int WIDTH       = 16,
  parameter  int APPROX_BITS = 3,
  parameter  int GUARD       = 8,
  parameter  int SATURATE    = 1,
  localparam int ACC_W       = 2*WIDTH + GUARD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_approx,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2*WIDTH-1:0] in_c,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_r,
  output logic               out_ovf
);
  localparam int PW = 2*WIDTH;

  typedef enum logic {FIRST, ACCUM} frame_t;

  // Each partial-product row loses its APPROX_BITS lowest result columns.
  function automatic logic [PW-1:0] approx_product(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic [PW-1:0] sum;
    logic [PW-1:0] row;
    logic [PW-1:0] mask;
    sum  = '0;
    mask = ~((PW'(1) << APPROX_BITS) - PW'(1));
    for (int i = 0; i < WIDTH; i++) begin
      row = PW'(a & {WIDTH{b[i]}}) << i;
      sum = sum + (row & mask);
    end
    return sum;
  endfunction

  frame_t           frame;
  logic             adv;
  logic             s1_valid, s1_mode, s1_last;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [PW-1:0]    s1_c;
  logic             s2_valid, s2_last;
  logic [PW-1:0]    s2_p, s2_c;
  logic [ACC_W-1:0] acc;
  logic             acc_ovf;
  logic             s3_last;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_mode  <= mode_approx;
      s1_last  <= in_last;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_c     <= in_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_p     <= '0;
      s2_c     <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_p     <= s1_mode ? approx_product(s1_a, s1_b) : PW'(s1_a) * PW'(s1_b);
      s2_c     <= s1_c;
    end
  end

  // The carry out of the wide add is the overflow; saturation pins the sum at all-ones.
  always_comb begin
    base     = (frame == FIRST) ? ACC_W'(s2_c) : acc;
    sum      = {1'b0, base} + {1'b0, ACC_W'(s2_p)};
    acc_next = sum[ACC_W-1:0];
    if (sum[ACC_W] && SATURATE != 0) acc_next = '1;
    ovf_next = sum[ACC_W] | ((frame == ACCUM) & acc_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
      frame   <= FIRST;
      s3_last <= 1'b0;
    end else if (adv) begin
      s3_last <= s2_valid & s2_last;
      if (s2_valid) begin
        acc     <= acc_next;
        acc_ovf <= ovf_next;
        frame   <= s2_last ? FIRST : ACCUM;
      end
    end
  end

  // A finished frame lands here; an un-consumed result freezes the whole pipeline via adv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= s3_last;
      if (s3_last) begin
        out_r   <= acc;
        out_ovf <= acc_ovf;
      end
    end
  end
endmodule

// File: tb/tb_approx_mac_stream.sv
// Directed bench for approx_mac_stream: scoreboard of expected frame results plus explicit
// latency, stall, saturation/wrap and mid-frame reset checks.
module tb_approx_mac_stream;
  localparam int WIDTH = 16;
  localparam int AB    = 3;
  localparam int ACC_W = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mode_approx = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [31:0] in_c = '0;

  logic        in_ready, out_valid, out_ovf;
  logic [39:0] out_r;
  logic        in_ready_s, out_valid_s, out_ovf_s;
  logic [31:0] out_r_s;
  logic        in_ready_w, out_valid_w, out_ovf_w;
  logic [31:0] out_r_w;

  approx_mac_stream #(.WIDTH(WIDTH), .APPROX_BITS(AB), .GUARD(8), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .mode_approx(mode_approx), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_ovf(out_ovf));

  approx_mac_stream #(.WIDTH(WIDTH), .APPROX_BITS(AB), .GUARD(0), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mode_approx(mode_approx), .in_valid(in_valid),
    .in_ready(in_ready_s), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_r(out_r_s), .out_ovf(out_ovf_s));

  approx_mac_stream #(.WIDTH(WIDTH), .APPROX_BITS(AB), .GUARD(0), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .mode_approx(mode_approx), .in_valid(in_valid),
    .in_ready(in_ready_w), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_last(in_last),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_r(out_r_w), .out_ovf(out_ovf_w));

  typedef struct {
    logic [39:0] r;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [63:0] m_acc = '0;
  bit          m_first = 1'b1;
  bit          m_ovf = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product built bit by bit: column i+j survives unless approx drops it.
  function automatic logic [63:0] modelProduct(input logic [15:0] a, input logic [15:0] b,
                                               input logic approx);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        if (a[j] && b[i] && (!approx || (i + j) >= AB)) p = p + (64'(1) << (i + j));
    return p;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [31:0] c,
                               input logic mode, input logic last);
    int          n;
    logic [63:0] s;
    logic [63:0] mask;
    in_a = a; in_b = b; in_c = c; mode_approx = mode; in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      idle(1);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("accept_timeout", 64'(n < 100), 64'(1));
    mask = (64'(1) << ACC_W) - 64'(1);
    s = (m_first ? 64'(c) : m_acc) + modelProduct(a, b, mode);
    if (m_first) m_ovf = 1'b0;
    if ((s >> ACC_W) != 0) begin
      m_ovf = 1'b1;
      s     = mask;
    end
    m_acc   = s;
    m_first = last;
    if (last) sb.push_back('{r: s[39:0], ovf: m_ovf});
  endtask

  // Scoreboard pop: a result is consumed at the next rising edge when valid and ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("[TB] FAIL unexpected_result: observed 0x%0h expected none", out_r);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("result_r", 64'(out_r), 64'(e.r));
        checkOutput("result_ovf", 64'(out_ovf), 64'(e.ovf));
      end
    end
  end

  initial begin
    int n;
    idle(2);
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_out_r", 64'(out_r), 64'(0));
    checkOutput("reset_out_ovf", 64'(out_ovf), 64'(0));
    rst_n = 1'b1;
    idle(1);
    checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
    checkOutput("reset_in_ready_sat", 64'(in_ready_s), 64'(1));
    checkOutput("reset_in_ready_wrap", 64'(in_ready_w), 64'(1));

    // Exact single beat with latency probe
    applyStimulus(16'h00FF, 16'h0003, 32'h10, 1'b0, 1'b1);
    checkOutput("lat_t0", 64'(out_valid), 64'(0));
    idle(1);
    checkOutput("lat_t1", 64'(out_valid), 64'(0));
    idle(1);
    checkOutput("lat_t2", 64'(out_valid), 64'(0));
    idle(1);
    checkOutput("lat_t3", 64'(out_valid), 64'(1));
    checkOutput("exact_single_r", 64'(out_r), 64'h30D);
    idle(3);

    // Approximate single beats
    applyStimulus(16'h00FF, 16'h0003, 32'h0, 1'b1, 1'b1);
    applyStimulus(16'h0007, 16'h0001, 32'h0, 1'b1, 1'b1);
    idle(5);

    // Four-beat frame with bubbles; bias on later beats must be ignored
    applyStimulus(16'd1, 16'd10, 32'd5, 1'b0, 1'b0);
    applyStimulus(16'd2, 16'd10, 32'hDEAD, 1'b0, 1'b0);
    applyStimulus(16'd3, 16'd10, 32'hBEEF, 1'b0, 1'b0);
    idle(6);
    checkOutput("frame_no_early_valid", 64'(out_valid), 64'(0));
    applyStimulus(16'd4, 16'd10, 32'h1234, 1'b0, 1'b1);
    checkOutput("frame_model_105", m_acc, 64'd105);
    idle(5);

    // Overflow: saturating and wrapping narrow instances
    applyStimulus(16'hFFFF, 16'hFFFF, 32'h0, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 32'h0, 1'b0, 1'b1);
    n = 0;
    while (!out_valid_s && n < 20) begin
      idle(1);
      n++;
    end
    checkOutput("ovf_wait", 64'(n < 20), 64'(1));
    checkOutput("sat_r", 64'(out_r_s), 64'hFFFFFFFF);
    checkOutput("sat_ovf", 64'(out_ovf_s), 64'(1));
    checkOutput("wrap_valid", 64'(out_valid_w), 64'(1));
    checkOutput("wrap_r", 64'(out_r_w), 64'hFFFC0002);
    checkOutput("wrap_ovf", 64'(out_ovf_w), 64'(1));
    idle(5);

    // Back-pressure with a second frame in flight
    out_ready = 1'b0;
    applyStimulus(16'h1234, 16'h0011, 32'd7, 1'b0, 1'b1);
    applyStimulus(16'h00FF, 16'h00FF, 32'd1, 1'b1, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      idle(1);
      n++;
    end
    checkOutput("stall_wait", 64'(n < 20), 64'(1));
    repeat (5) begin
      idle(1);
      checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
      checkOutput("stall_out_valid", 64'(out_valid), 64'(1));
      checkOutput("stall_out_r", 64'(out_r), 64'(sb[0].r));
    end
    out_ready = 1'b1;
    idle(1);
    checkOutput("stall_next_valid", 64'(out_valid), 64'(1));
    checkOutput("stall_next_r", 64'(out_r), 64'(sb[0].r));
    idle(4);

    // Mixed-mode frames of varying length, back to back
    for (int f = 1; f <= 4; f++)
      for (int k = 0; k < f; k++)
        applyStimulus(16'($urandom), 16'($urandom), 32'($urandom), 1'($urandom), 1'(k == f - 1));
    idle(6);

    // Reset mid-frame discards the partial accumulation
    applyStimulus(16'd100, 16'd100, 32'd9, 1'b0, 1'b0);
    applyStimulus(16'd200, 16'd100, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n   = 1'b1;
    m_first = 1'b1;
    repeat (5) begin
      idle(1);
      checkOutput("reset_mid_no_valid", 64'(out_valid), 64'(0));
    end
    applyStimulus(16'd2, 16'd3, 32'd0, 1'b0, 1'b1);
    checkOutput("reset_mid_model_6", m_acc, 64'd6);
    idle(8);
    checkOutput("scoreboard_drain", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
